// File: rtl/adder_sequencer_if.sv
// Operand/result handshake bundle for adder_sequencer.
// The producer/consumer side uses the master modport; the block uses slave.
interface adder_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] augend;
  logic [WIDTH-1:0] addend;
  logic             sub;
  logic             cin;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, augend, addend, sub, cin, out_ready,
    input  in_ready, busy, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, augend, addend, sub, cin, out_ready,
    output in_ready, busy, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/adder_sequencer.sv
// Multi-cycle add/subtract: one SLICE-bit adder is reused over N = WIDTH/SLICE
// cycles, rippling the carry through a register from the LSB slice upward.
// WIDTH must be an integer multiple of SLICE; SLICE = WIDTH gives one RUN cycle.
module adder_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic               clk,
  input  logic               reset,
  adder_sequencer_if.slave   bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;       // latched augend
  logic [WIDTH-1:0]   b_q, b_d;       // latched addend, already inverted for subtract
  logic [WIDTH-1:0]   res_q, res_d;   // result, filled one slice per RUN cycle
  logic               c_q, c_d;       // ripple carry between slices
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [SLICE-1:0]   a_slice;
  logic [SLICE-1:0]   b_slice;
  logic [SLICE:0]     slice_sum;
  logic               last_slice;

  // Shared slice adder: current slice of both operands plus the ripple carry
  always_comb begin
    a_slice    = a_q[int'(idx_q)*SLICE +: SLICE];
    b_slice    = b_q[int'(idx_q)*SLICE +: SLICE];
    slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, c_q};
    last_slice = (idx_q == IDX_W'(N - 1));
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE sequencing
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.augend;
          b_d     = bus.addend ^ {WIDTH{bus.sub}};
          c_d     = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[int'(idx_q)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        c_d   = slice_sum[SLICE];
        idx_d = idx_q + 1'b1;
        if (last_slice) begin
          // The top slice's MSB is the result sign bit.
          carry_d = slice_sum[SLICE];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_sum[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that also aborts any operation
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = res_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, the width of the internal adder slice; WIDTH SHALL be an integer multiple of SLICE, and N = WIDTH/SLICE.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, indicating that the operands are presented.
REQ-006 The block SHALL have port in_ready, output, 1, indicating that the block accepts operands.
REQ-007 The block SHALL have port augend, input, WIDTH, the first operand.
REQ-008 The block SHALL have port addend, input, WIDTH, the second operand.
REQ-009 The block SHALL have port sub, input, 1, selecting the operation: 1 = augend - addend, 0 = add.
REQ-010 The block SHALL have port cin, input, 1, the carry-in for an add; cin is ignored when sub=1.
REQ-011 The block SHALL have port busy, output, 1, high while slices are being computed.
REQ-012 The block SHALL have port out_valid, output, 1, indicating that the result is presented.
REQ-013 The block SHALL have port out_ready, input, 1, indicating that the consumer accepts the result.
REQ-014 The block SHALL have port sum, output, WIDTH, the result.
REQ-015 The block SHALL have port carry, output, 1, the carry out of the MSB; for subtraction 1 = no borrow.
REQ-016 The block SHALL have port overflow, output, 1, the two's-complement signed overflow flag.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE; in_ready=1 only in IDLE, busy=1 only in RUN, and out_valid=1 only in DONE.
REQ-018 In IDLE with in_valid=1, the block SHALL:
- latch augend;
- latch addend XOR {WIDTH{sub}};
- set the carry register to sub ? 1 : cin;
- clear the slice index;
- go to RUN.
REQ-019 In RUN, each cycle SHALL add slice[idx] of both latched operands plus the carry register using one SLICE-bit adder.
REQ-020 In RUN, each cycle SHALL write that SLICE-bit sum into result slice idx, load the adder carry-out into the carry register, and increment idx.
REQ-021 When idx = N-1 in RUN, the block SHALL go to DONE and SHALL set the carry output from the final carry-out.
REQ-022 In the same final RUN cycle, overflow SHALL be set to (a_msb == b_eff_msb) && (sum_msb != a_msb).
REQ-023 out_valid SHALL rise exactly N rising edges after the acceptance edge, which is 4 edges for the defaults.
REQ-024 In DONE, sum, carry and overflow SHALL hold stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-025 Back-to-back operation SHALL insert exactly one IDLE cycle between a result handshake and the next acceptance.
REQ-026 in_valid SHALL be ignored in RUN and DONE, with no latching and no side effects.
REQ-027 sum SHALL be defined only while out_valid=1; partial slice updates during RUN are permitted.
REQ-028 SLICE = WIDTH (N=1) SHALL be a legal configuration with a single RUN cycle.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL go to IDLE and clear the operand, result, carry, idx and overflow registers to 0.
REQ-030 The outputs after reset SHALL be in_ready=1, busy=0, out_valid=0, sum=0, carry=0 and overflow=0.
REQ-031 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; reset SHALL take priority over every simultaneous event.

Verification
REQ-032 The bench SHALL cover reset: reset for 2 cycles, then release -> in_ready=1, busy=0, out_valid=0, sum=0, carry=0, overflow=0.
REQ-033 The bench SHALL cover cross-slice ripple: 0x000000FF + 0x00000001, cin=0 -> out_valid 4 edges after acceptance, sum=0x00000100, carry=0, overflow=0.
REQ-034 The bench SHALL cover full wrap and positive overflow:
- 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, carry=1, overflow=0;
- 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, carry=0, overflow=1.
REQ-035 The bench SHALL cover subtract: 0x80000000 - 0x00000001, sub=1, cin=1 ignored -> sum=0x7FFFFFFF, carry=1, overflow=1.
REQ-036 The bench SHALL cover backpressure:
- stimulus: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands;
- response: out_valid, sum and carry stay constant and the new operands are not taken;
- after the handshake, the next operands are accepted one cycle later.
REQ-037 The bench SHALL cover mid-run reset: reset asserted 2 cycles after acceptance -> the next cycle is IDLE with out_valid=0 and sum=0, and a following 0x12345678 + 0x11111111 gives 0x23456789.
